// File: rtl/fpdiv_multi_ch_pkg.sv
// Shared constants for the multi-channel divider front-end.
// Field widths, rounding-mode encodings and tag width helper.
package fpdiv_multi_ch_pkg;

    localparam int FP_FMT_W = 2;
    localparam int RM_W     = 3;
    localparam int FP_W     = 64;
    localparam int FFLAGS_W = 5;

    localparam logic [RM_W-1:0] RM_RNE = 3'b000;
    localparam logic [RM_W-1:0] RM_RTZ = 3'b001;
    localparam logic [RM_W-1:0] RM_RDN = 3'b010;
    localparam logic [RM_W-1:0] RM_RUP = 3'b011;
    localparam logic [RM_W-1:0] RM_RMM = 3'b100;

    // Channel tag width; never below one bit.
    function automatic int tag_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fpdiv_tag_fifo.sv
// In-order tag FIFO: records issuing channel per in-flight op.
// Ports: clk, rst, flush, push/din, pop, full, empty, count, head.
module fpdiv_tag_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= nxt(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= nxt(rd_ptr);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fpdiv_multi_ch_arb.sv
// Round-robin N-channel front-end sharing one fpdiv_scalar_r64.
// Ports: ch_* requester side, div_* divider side, flush_i, status.
// Optional FPDIV_MULTI_CH_ARB_PERF_CNT_EN adds per-channel
// perf_done_cnt_o / perf_stall_cnt_o saturating counters.
module fpdiv_multi_ch_arb
    import fpdiv_multi_ch_pkg::*;
#(
    parameter int NUM_CH          = 4,
    parameter int MAX_OUTSTANDING = 2,
    parameter int TAG_W           = tag_width(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic [NUM_CH-1:0]            ch_start_valid_i,
    output logic [NUM_CH-1:0]            ch_start_ready_o,
    input  logic [FP_FMT_W*NUM_CH-1:0]   ch_fp_format_i,
    input  logic [FP_W*NUM_CH-1:0]       ch_opa_i,
    input  logic [FP_W*NUM_CH-1:0]       ch_opb_i,
    input  logic [RM_W*NUM_CH-1:0]       ch_rm_i,
    output logic [NUM_CH-1:0]            ch_finish_valid_o,
    input  logic [NUM_CH-1:0]            ch_finish_ready_i,
    output logic [FP_W*NUM_CH-1:0]       ch_res_o,
    output logic [FFLAGS_W*NUM_CH-1:0]   ch_fflags_o,
    output logic                         div_start_valid_o,
    input  logic                         div_start_ready_i,
    output logic [FP_FMT_W-1:0]          div_fp_format_o,
    output logic [FP_W-1:0]              div_opa_o,
    output logic [FP_W-1:0]              div_opb_o,
    output logic [RM_W-1:0]              div_rm_o,
    output logic                         div_flush_o,
    input  logic                         div_finish_valid_i,
    output logic                         div_finish_ready_o,
    input  logic [FP_W-1:0]              div_res_i,
    input  logic [FFLAGS_W-1:0]          div_fflags_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
`ifdef FPDIV_MULTI_CH_ARB_PERF_CNT_EN
    output logic [32*NUM_CH-1:0]         perf_done_cnt_o,
    output logic [32*NUM_CH-1:0]         perf_stall_cnt_o,
`endif
    output logic                         orphan_err_o
);

    logic [TAG_W-1:0] rr_ptr;
    logic [TAG_W-1:0] grant;
    logic [TAG_W-1:0] head;
    logic             any_valid;
    logic             fifo_full;
    logic             fifo_empty;
    logic             can_issue;
    logic             issue_hs;
    logic             head_ok;
    logic             pop;
    int               idx;

    // Scan from rr_ptr, wrapping, and take the first valid channel.
    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!any_valid && ch_start_valid_i[idx]) begin
                any_valid = 1'b1;
                grant     = TAG_W'(idx);
            end
        end
    end

    // Reset gates the combinational handshakes so nothing leaks out.
    assign can_issue = any_valid && !fifo_full && !flush_i && !rst;
    assign issue_hs  = can_issue && div_start_ready_i;
    assign head_ok   = !fifo_empty && !flush_i && !rst;

    assign div_start_valid_o = can_issue;
    assign div_fp_format_o   = ch_fp_format_i[int'(grant)*FP_FMT_W +: FP_FMT_W];
    assign div_opa_o         = ch_opa_i[int'(grant)*FP_W +: FP_W];
    assign div_opb_o         = ch_opb_i[int'(grant)*FP_W +: FP_W];
    assign div_rm_o          = ch_rm_i[int'(grant)*RM_W +: RM_W];
    assign div_flush_o       = flush_i;

    assign div_finish_ready_o = head_ok && ch_finish_ready_i[head];
    assign pop                = div_finish_valid_i && div_finish_ready_o;

    always_comb begin
        ch_start_ready_o  = '0;
        ch_finish_valid_o = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_start_ready_o[c]  = issue_hs && (grant == TAG_W'(c));
            ch_finish_valid_o[c] = head_ok && div_finish_valid_i
                                   && (head == TAG_W'(c));
        end
    end

    assign ch_res_o    = {NUM_CH{div_res_i}};
    assign ch_fflags_o = {NUM_CH{div_fflags_i}};

    fpdiv_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (TAG_W)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush_i),
        .push  (issue_hs),
        .din   (grant),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (outstanding_o),
        .head  (head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr       <= '0;
            orphan_err_o <= 1'b0;
        end else begin
            if (issue_hs) begin
                rr_ptr <= (grant == TAG_W'(NUM_CH - 1))
                          ? '0 : grant + TAG_W'(1);
            end
            if (div_finish_valid_i && fifo_empty) begin
                orphan_err_o <= 1'b1;
            end
        end
    end

`ifdef FPDIV_MULTI_CH_ARB_PERF_CNT_EN
    for (genvar c = 0; c < NUM_CH; c++) begin : g_perf
        logic [31:0] done_cnt;
        logic [31:0] stall_cnt;

        always_ff @(posedge clk) begin
            if (rst) begin
                done_cnt  <= '0;
                stall_cnt <= '0;
            end else begin
                if (ch_finish_valid_o[c] && ch_finish_ready_i[c]
                    && (done_cnt != '1)) begin
                    done_cnt <= done_cnt + 32'd1;
                end
                if (ch_start_valid_i[c] && !ch_start_ready_o[c]
                    && (stall_cnt != '1)) begin
                    stall_cnt <= stall_cnt + 32'd1;
                end
            end
        end

        assign perf_done_cnt_o[c*32 +: 32]  = done_cnt;
        assign perf_stall_cnt_o[c*32 +: 32] = stall_cnt;
    end
`endif

endmodule

// File: tb/tb_fpdiv_multi_ch_arb.sv
// Directed bench for fpdiv_multi_ch_arb (NUM_CH=4, depth 2).
// Vector table plus sequences for reset, flush and backpressure.
module tb_fpdiv_multi_ch_arb;

    localparam int N = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic [N-1:0]     sv;
    logic [N-1:0]     sr;
    logic [2*N-1:0]   fmt;
    logic [64*N-1:0]  opa;
    logic [64*N-1:0]  opb;
    logic [3*N-1:0]   rm;
    logic [N-1:0]     cfv;
    logic [N-1:0]     fr;
    logic [64*N-1:0]  cres;
    logic [5*N-1:0]   cff;
    logic             dsv;
    logic             dsr;
    logic [1:0]       dfmt;
    logic [63:0]      dopa;
    logic [63:0]      dopb;
    logic [2:0]       drm;
    logic             dflush;
    logic             fv;
    logic             dfr;
    logic [63:0]      dres;
    logic [4:0]       dff;
    logic [1:0]       outst;
    logic             orphan;
`ifdef FPDIV_MULTI_CH_ARB_PERF_CNT_EN
    logic [32*N-1:0]  pdone;
    logic [32*N-1:0]  pstall;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fpdiv_multi_ch_arb #(
        .NUM_CH          (N),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .flush_i            (flush),
        .ch_start_valid_i   (sv),
        .ch_start_ready_o   (sr),
        .ch_fp_format_i     (fmt),
        .ch_opa_i           (opa),
        .ch_opb_i           (opb),
        .ch_rm_i            (rm),
        .ch_finish_valid_o  (cfv),
        .ch_finish_ready_i  (fr),
        .ch_res_o           (cres),
        .ch_fflags_o        (cff),
        .div_start_valid_o  (dsv),
        .div_start_ready_i  (dsr),
        .div_fp_format_o    (dfmt),
        .div_opa_o          (dopa),
        .div_opb_o          (dopb),
        .div_rm_o           (drm),
        .div_flush_o        (dflush),
        .div_finish_valid_i (fv),
        .div_finish_ready_o (dfr),
        .div_res_i          (dres),
        .div_fflags_i       (dff),
        .outstanding_o      (outst),
`ifdef FPDIV_MULTI_CH_ARB_PERF_CNT_EN
        .perf_done_cnt_o    (pdone),
        .perf_stall_cnt_o   (pstall),
`endif
        .orphan_err_o       (orphan)
    );

    typedef struct {
        logic [3:0] sv;
        logic       dsr;
        logic       fv;
        logic [3:0] fr;
        logic [3:0] sr;
        logic       dsv;
        int         g;
        logic [3:0] cfv;
        logic       dfr;
        int         out;
    } vec_t;

    vec_t vt[13];

    function automatic logic [63:0] opa_of(input int c);
        return 64'hA5A5_0000_0000_0000 + 64'(c);
    endfunction

    function automatic logic [63:0] opb_of(input int c);
        return 64'h5A5A_0000_0000_0100 + 64'(c);
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        flush = 1'b0;
        sv    = '0;
        fv    = 1'b0;
        fr    = '0;
        dsr   = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        for (int c = 0; c < N; c++) begin
            opa[c*64 +: 64] = opa_of(c);
            opb[c*64 +: 64] = opb_of(c);
            fmt[c*2 +: 2]   = 2'(3 - c);
            rm[c*3 +: 3]    = 3'(c + 1);
        end
        dres = 64'hDEAD_BEEF_0123_4567;
        dff  = 5'h15;

        vt[0]  = '{4'b1111, 1, 0, 4'b0000, 4'b0001, 1,  0, 4'b0000, 0, 0};
        vt[1]  = '{4'b1111, 0, 0, 4'b0000, 4'b0000, 1,  1, 4'b0000, 0, 1};
        vt[2]  = '{4'b1111, 1, 1, 4'b0000, 4'b0010, 1,  1, 4'b0001, 0, 1};
        vt[3]  = '{4'b1111, 1, 1, 4'b1110, 4'b0000, 0, -1, 4'b0001, 0, 2};
        vt[4]  = '{4'b1111, 1, 1, 4'b0001, 4'b0000, 0, -1, 4'b0001, 1, 2};
        vt[5]  = '{4'b1011, 1, 1, 4'b0010, 4'b1000, 1,  3, 4'b0010, 1, 1};
        vt[6]  = '{4'b0000, 1, 0, 4'b0000, 4'b0000, 0, -1, 4'b0000, 0, 1};
        vt[7]  = '{4'b0110, 1, 1, 4'b1000, 4'b0010, 1,  1, 4'b1000, 1, 1};
        vt[8]  = '{4'b0110, 1, 0, 4'b0000, 4'b0100, 1,  2, 4'b0000, 0, 1};
        vt[9]  = '{4'b0001, 1, 1, 4'b0010, 4'b0000, 0, -1, 4'b0010, 1, 2};
        vt[10] = '{4'b0001, 1, 1, 4'b0100, 4'b0001, 1,  0, 4'b0100, 1, 1};
        vt[11] = '{4'b0000, 1, 1, 4'b0001, 4'b0000, 0, -1, 4'b0001, 1, 1};
        vt[12] = '{4'b0000, 1, 0, 4'b0000, 4'b0000, 0, -1, 4'b0000, 0, 0};

        // Reset held with every request line active.
        rst   = 1'b1;
        flush = 1'b0;
        sv    = 4'b1111;
        fv    = 1'b1;
        fr    = 4'b1111;
        dsr   = 1'b1;
        tick();
        tick();
        #2;
        chk("rst sr", 64'(sr), 64'h0);
        chk("rst dsv", 64'(dsv), 64'h0);
        chk("rst cfv", 64'(cfv), 64'h0);
        chk("rst dfr", 64'(dfr), 64'h0);
        chk("rst outst", 64'(outst), 64'h0);
        chk("rst orphan", 64'(orphan), 64'h0);
        rst = 1'b0;
        sv  = '0;
        fv  = 1'b0;
        fr  = '0;
        @(negedge clk);
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) begin
            sv  = vt[i].sv;
            dsr = vt[i].dsr;
            fv  = vt[i].fv;
            fr  = vt[i].fr;
            #2;
            chk($sformatf("v%0d sr", i), 64'(sr), 64'(vt[i].sr));
            chk($sformatf("v%0d dsv", i), 64'(dsv), 64'(vt[i].dsv));
            chk($sformatf("v%0d cfv", i), 64'(cfv), 64'(vt[i].cfv));
            chk($sformatf("v%0d dfr", i), 64'(dfr), 64'(vt[i].dfr));
            chk($sformatf("v%0d outst", i), 64'(outst), 64'(vt[i].out));
            if (vt[i].dsv) begin
                chk($sformatf("v%0d opa", i), dopa, opa_of(vt[i].g));
                chk($sformatf("v%0d opb", i), dopb, opb_of(vt[i].g));
                chk($sformatf("v%0d fmt", i), 64'(dfmt), 64'(3 - vt[i].g));
                chk($sformatf("v%0d rm", i), 64'(drm), 64'(vt[i].g + 1));
            end
            tick();
        end
        chk("lane2 res", cres[2*64 +: 64], 64'hDEAD_BEEF_0123_4567);
        chk("lane3 fflags", 64'(cff[3*5 +: 5]), 64'h15);
        chk("table orphan", 64'(orphan), 64'h0);

        // Only channel 2 requests; then rr_ptr must sit at 3.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            sv = 4'b0100;
            fv = 1'b0;
            fr = '0;
            #2;
            chk($sformatf("sparse%0d sr", k), 64'(sr), 64'h4);
            chk($sformatf("sparse%0d opa", k), dopa, opa_of(2));
            tick();
            sv = '0;
            fv = 1'b1;
            fr = 4'b0100;
            #2;
            chk($sformatf("sparse%0d cfv", k), 64'(cfv), 64'h4);
            tick();
        end
        fv = 1'b0;
        fr = '0;
        sv = 4'b1001;
        #2;
        chk("sparse rr3", 64'(sr), 64'h8);
        tick();
        sv = '0;
        fv = 1'b1;
        fr = 4'b1000;
        tick();
        fv = 1'b0;
        fr = '0;

        // Channel 1 result stalls at head for 20 cycles.
        do_reset();
        sv = 4'b0010;
        tick();
        sv = 4'b0100;
        tick();
        sv = 4'b1111;
        fv = 1'b1;
        fr = 4'b1101;
        for (int k = 0; k < 20; k++) begin
            #2;
            chk($sformatf("bp%0d dfr", k), 64'(dfr), 64'h0);
            chk($sformatf("bp%0d outst", k), 64'(outst), 64'h2);
            chk($sformatf("bp%0d dsv", k), 64'(dsv), 64'h0);
            chk($sformatf("bp%0d cfv", k), 64'(cfv), 64'h2);
            tick();
        end
        sv = '0;
        fr = 4'b1111;
        #2;
        chk("drain0 cfv", 64'(cfv), 64'h2);
        chk("drain0 dfr", 64'(dfr), 64'h1);
        tick();
        #2;
        chk("drain1 cfv", 64'(cfv), 64'h4);
        chk("drain1 outst", 64'(outst), 64'h1);
        tick();
        fv = 1'b0;
        #2;
        chk("drain2 outst", 64'(outst), 64'h0);

        // Flush with two outstanding, then a late result.
        do_reset();
        sv = 4'b0001;
        tick();
        sv = 4'b0010;
        tick();
        flush = 1'b1;
        sv    = 4'b1111;
        fv    = 1'b1;
        fr    = 4'b1111;
        #2;
        chk("flush dsv", 64'(dsv), 64'h0);
        chk("flush sr", 64'(sr), 64'h0);
        chk("flush cfv", 64'(cfv), 64'h0);
        chk("flush dfr", 64'(dfr), 64'h0);
        chk("flush mirror", 64'(dflush), 64'h1);
        tick();
        flush = 1'b0;
        fv    = 1'b0;
        dsr   = 1'b0;
        #2;
        chk("post flush outst", 64'(outst), 64'h0);
        chk("post flush orphan", 64'(orphan), 64'h0);
        chk("post flush rr", dopa, opa_of(2));
        tick();
        sv  = '0;
        dsr = 1'b1;
        fv  = 1'b1;
        #2;
        chk("late cfv", 64'(cfv), 64'h0);
        chk("late dfr", 64'(dfr), 64'h0);
        tick();
        fv = 1'b0;
        #2;
        chk("late orphan", 64'(orphan), 64'h1);

        // Reset mid-operation with two outstanding.
        sv = 4'b0001;
        tick();
        sv = 4'b0010;
        tick();
        sv = '0;
        #2;
        chk("pre rst outst", 64'(outst), 64'h2);
        rst = 1'b1;
        sv  = 4'b1111;
        fv  = 1'b1;
        fr  = 4'b1111;
        #2;
        chk("midrst dsv", 64'(dsv), 64'h0);
        chk("midrst sr", 64'(sr), 64'h0);
        chk("midrst cfv", 64'(cfv), 64'h0);
        chk("midrst dfr", 64'(dfr), 64'h0);
        tick();
        #2;
        chk("midrst outst", 64'(outst), 64'h0);
        chk("midrst orphan", 64'(orphan), 64'h0);
`ifdef FPDIV_MULTI_CH_ARB_PERF_CNT_EN
        chk("midrst pdone", 64'(pdone[31:0]), 64'h0);
        chk("midrst pstall", 64'(pstall[31:0]), 64'h0);
`endif
        rst = 1'b0;
        fv  = 1'b0;
        fr  = '0;
        #2;
        chk("midrst rr0", 64'(sr), 64'h1);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fpdiv_multi_ch_arb.md
Name: fpdiv_multi_ch_arb

Overview:
- Parametrised N-channel front-end that shares one fpdiv_scalar_r64 instance between NUM_CH independent requesters.
- Arbitrates requests round-robin and issues them to the divider.
- Records the issuing channel in an in-order tag FIFO, which supports a pipelined divider with up to MAX_OUTSTANDING ops in flight.
- Routes each result and its fflags back to the owning channel, with per-channel valid-ready and backpressure.

Parameters:
- NUM_CH, 4, number of requester channels (2..16).
- MAX_OUTSTANDING, 2, tag FIFO depth = max divider ops in flight (1 = serial divider).
- TAG_W, $clog2(NUM_CH), derived; channel tag width (min 1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush_i  in  1  abort all in-flight ops.
- ch_start_valid_i  in  NUM_CH  per-channel request valid.
- ch_start_ready_o  out  NUM_CH  per-channel request accepted.
- ch_fp_format_i  in  2*NUM_CH  packed fp format, channel c at [2c+1:2c].
- ch_opa_i  in  64*NUM_CH  packed operand A.
- ch_opb_i  in  64*NUM_CH  packed operand B.
- ch_rm_i  in  3*NUM_CH  packed rounding mode.
- ch_finish_valid_o  out  NUM_CH  per-channel result valid.
- ch_finish_ready_i  in  NUM_CH  per-channel result ready.
- ch_res_o  out  64*NUM_CH  result; all lanes carry div_res_i, qualified by valid.
- ch_fflags_o  out  5*NUM_CH  fflags; all lanes carry div_fflags_i.
- div_start_valid_o  out  1  to divider.
- div_start_ready_i  in  1  from divider.
- div_fp_format_o  out  2  granted channel's format.
- div_opa_o  out  64  granted channel's operand A.
- div_opb_o  out  64  granted channel's operand B.
- div_rm_o  out  3  granted channel's rounding mode.
- div_flush_o  out  1  = flush_i.
- div_finish_valid_i  in  1  from divider.
- div_finish_ready_o  out  1  to divider.
- div_res_i  in  64  divider result.
- div_fflags_i  in  5  divider fflags.
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  tag FIFO occupancy.
- orphan_err_o  out  1  sticky: divider finish_valid seen while FIFO empty.

Behaviour:
- Reset (rst=1 at posedge):
  - rr_ptr=0, FIFO empty, outstanding_o=0, orphan_err_o=0.
  - All *_valid_o and ch_start_ready_o are 0 while rst is held; combinational outputs are forced low during rst.
  - Reset mid-operation drops all tags. The divider is reset by the same reset domain.
- Arbitration, combinational:
  - grant = first c with ch_start_valid_i[c]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_CH.
  - can_issue = any valid & !fifo_full & !flush_i.
  - div_start_valid_o = can_issue. div_* operands are muxed from the grant; no operand register, zero added latency.
  - ch_start_ready_o[c] = (c==grant) & can_issue & div_start_ready_i. A non-granted channel never sees ready.
- Issue handshake (div_start_valid_o & div_start_ready_i):
  - Push grant tag into the FIFO.
  - rr_ptr <= (grant+1) mod NUM_CH. rr_ptr is unchanged if no handshake.
- Push blocking: push is blocked only by full. No push-when-full even if a pop occurs in the same cycle (keeps the ready path short).
- Result routing:
  - head = FIFO head tag.
  - ch_finish_valid_o[c] = !empty & div_finish_valid_i & (head==c).
  - div_finish_ready_o = !empty & ch_finish_ready_i[head].
  - Pop on div_finish_valid_i & div_finish_ready_o.
  - Simultaneous push and pop: occupancy unchanged, both take effect.
- Ordering:
  - Results return in issue order.
  - A stalled head channel backpressures the divider and, via full, all channels.
  - Other channels' finish_ready is ignored.
- Orphan: div_finish_valid_i=1 with FIFO empty sets orphan_err_o (sticky until rst). div_finish_ready_o stays 0.
- Flush (flush_i=1, one cycle):
  - FIFO cleared at the next edge; no issue and no result delivery in that cycle.
  - rr_ptr is kept. div_flush_o mirrors flush_i combinationally.
- Pointers: FIFO read/write pointers wrap modulo MAX_OUTSTANDING. Occupancy counter ranges 0..MAX_OUTSTANDING.

Optional Feature:
- Macro: FPDIV_MULTI_CH_ARB_PERF_CNT_EN.
- When defined:
  - Adds output perf_done_cnt_o (32*NUM_CH): per-channel completed-result counters, incremented on each finish handshake.
  - Adds output perf_stall_cnt_o (32*NUM_CH): per-channel stall counters, incremented each cycle ch_start_valid_i[c]=1 & ch_start_ready_o[c]=0.
  - Both saturate at 2^32-1 and clear on rst only; flush does not clear them.
- When undefined: ports and logic are absent.

Decomposition:
- Package fpdiv_multi_ch_pkg holds:
  - constants FP_FMT_W=2, RM_W=3, FP_W=64, FFLAGS_W=5;
  - RM_RNE/RTZ/RDN/RUP/RMM encodings;
  - tag typedef helper.
- One sub-module, fpdiv_tag_fifo: parametrised depth/width sync FIFO with push, pop, flush, full, empty, count, head.

Test Plan:
- Fairness: NUM_CH=4, all channels continuously valid, MAX_OUTSTANDING=2, divider latency 10 → issue order 0,1,2,3,0,...; each channel 25% of 400 results; results bit-match the cmodel.
- Sparse: only ch2 valid after reset → grant=2 every issue; rr_ptr ends 3; ch_start_ready_o of ch0/1/3 stays 0.
- Backpressure: ch1 holds finish_ready=0 for 20 cycles with its result at head → div_finish_ready_o=0, outstanding_o=2, no further issues; release → in-order drain.
- Simultaneous push/pop at outstanding_o=1 → stays 1; no push at outstanding_o=2 even when a pop occurs in the same cycle.
- Flush with 2 outstanding → outstanding_o=0 next cycle, no ch_finish_valid_o; a late div_finish_valid_i afterwards → orphan_err_o=1.
- Reset asserted mid-op with 2 outstanding → all valids/readies 0, outstanding_o=0, rr_ptr=0; perf counters (if enabled) read 0.
